// File: rtl/dl_pkg.sv
// Shared constants and types for the design-library storage primitives.
package dl_pkg;

   localparam int unsigned DL_DATA_W = 32;

   typedef logic [DL_DATA_W-1:0] dl_word_t;

   localparam dl_word_t DL_RST_VAL_DEFAULT = '0;

endpackage

// File: rtl/dl_dff_arst.sv
// Single-bit D flop with asynchronous active-low reset to a fixed value.
module dl_dff_arst #(
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q <= RST_VAL;
      end else begin
         q <= d;
      end
   end

endmodule

// File: rtl/dl_reg_arst.sv
// NUM_BITS-wide D register with async active-low reset to RST_VAL.
// Define DL_REG_ARST_ASSERT_EN to compile in the embedded SVA checks.
module dl_reg_arst
   import dl_pkg::*;
#(
   parameter int unsigned          NUM_BITS = DL_DATA_W,
   parameter logic [NUM_BITS-1:0] RST_VAL  = NUM_BITS'(DL_RST_VAL_DEFAULT)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [NUM_BITS-1:0] d,
   output logic [NUM_BITS-1:0] q
);

   // Each bit is an independent flop so per-bit reset values map directly.
   for (genvar i = 0; i < NUM_BITS; i++) begin : g_bit
      dl_dff_arst #(
         .RST_VAL (RST_VAL[i])
      ) u_dff (
         .clk   (clk),
         .rst_n (rst_n),
         .d     (d[i]),
         .q     (q[i])
      );
   end

`ifdef DL_REG_ARST_ASSERT_EN
   if (NUM_BITS < 1) begin : g_bad_width
      $error("%m: NUM_BITS must be at least 1");
   end

   a_rst_val: assert property (@(posedge clk) !rst_n |-> (q == RST_VAL))
      else $error("%m: q differs from RST_VAL while in reset at %0t", $time);

   a_capture: assert property (@(posedge clk) disable iff (!rst_n)
                               (rst_n && $past(rst_n)) |-> (q == $past(d)))
      else $error("%m: q does not match d from the previous edge at %0t", $time);

   a_d_known: assert property (@(posedge clk) rst_n |-> !$isunknown(d))
      else $error("%m: d is X/Z on a clock edge out of reset at %0t", $time);
`endif

endmodule

// File: tb/tb_dl_reg_arst.sv
// Directed plus randomized self-checking bench for dl_reg_arst (32-bit and 1-bit).
module tb_dl_reg_arst;

   localparam logic [31:0] RST32 = 32'hc0ffee69;

   logic        clk;
   logic        rst_n;
   logic [31:0] d;
   logic [31:0] q;
   logic        rst1_n;
   logic        d1;
   logic        q1;

   int checks = 0;
   int errors = 0;

   dl_reg_arst #(
      .NUM_BITS (32),
      .RST_VAL  (RST32)
   ) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (d),
      .q     (q)
   );

   dl_reg_arst #(
      .NUM_BITS (1),
      .RST_VAL  (1'b1)
   ) u_dut1 (
      .clk   (clk),
      .rst_n (rst1_n),
      .d     (d1),
      .q     (q1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   initial begin
      logic [31:0] exp_q;
      logic        nrst;

      rst_n  = 1'b1;
      rst1_n = 1'b1;
      d      = '0;
      d1     = 1'b0;

      // Reset asserted between edges, before any clock edge.
      #2;
      rst_n  = 1'b0;
      rst1_n = 1'b0;
      #1;
      check("reset_state", q, RST32);
      check("reset_state_w1", {31'b0, q1}, 32'h1);

      // Release mid-cycle and capture on the first edge.
      @(negedge clk);
      d      = 32'h12345678;
      rst_n  = 1'b1;
      rst1_n = 1'b1;
      d1     = 1'b0;
      @(posedge clk); #1;
      check("first_capture", q, 32'h12345678);
      check("w1_capture0", {31'b0, q1}, 32'h0);

      // Async assert between edges.
      #2;
      rst_n = 1'b0;
      #0;
      #1;
      check("async_assert", q, RST32);
      @(negedge clk);
      check("async_hold_pre_edge", q, RST32);

      // Hold in reset with toggling data.
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         d = (i % 2 == 0) ? 32'hffffffff : 32'h0;
         @(posedge clk); #1;
         check("hold_in_reset", q, RST32);
      end

      // Release mid-cycle: q must not change until the next edge.
      @(negedge clk);
      d = 32'hdeadbeef;
      #1;
      rst_n = 1'b1;
      #1;
      check("release_no_early", q, RST32);
      @(posedge clk); #1;
      check("release_capture", q, 32'hdeadbeef);

      // Pipeline latency: one cycle per value, stable between edges.
      @(negedge clk); d = 32'h1;
      @(posedge clk); #1; check("pipe_1", q, 32'h1);
      @(negedge clk); d = 32'h2; #1; check("pipe_stable", q, 32'h1);
      @(posedge clk); #1; check("pipe_2", q, 32'h2);
      @(negedge clk); d = 32'h3;
      @(posedge clk); #1; check("pipe_3", q, 32'h3);

      // Reset coincident with a clock edge wins over capture.
      @(negedge clk); d = 32'haaaaaaaa;
      @(posedge clk);
      rst_n = 1'b0;
      #1;
      check("coincident_reset", q, RST32);
      @(negedge clk); check("coincident_hold", q, RST32);
      rst_n = 1'b1;

      // 1-bit instance: capture 1 then reset back to 1 from 0.
      @(negedge clk); d1 = 1'b1;
      @(posedge clk); #1; check("w1_capture1", {31'b0, q1}, 32'h1);
      @(negedge clk); d1 = 1'b0;
      @(posedge clk); #1; check("w1_capture0b", {31'b0, q1}, 32'h0);
      #1; rst1_n = 1'b0; #1;
      check("w1_async_reset", {31'b0, q1}, 32'h1);
      @(negedge clk); rst1_n = 1'b1;

      // Randomized d and rst_n against a reference model.
      @(negedge clk);
      d = 32'h0badf00d;
      @(posedge clk); #1;
      exp_q = 32'h0badf00d;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         check("rand_q", q, exp_q);
         d    = $urandom;
         nrst = ($urandom_range(0, 5) != 0);
         rst_n = nrst;
         #1;
         if (!nrst) check("rand_async", q, RST32);
         exp_q = nrst ? d : RST32;
      end
      @(negedge clk);
      check("rand_final", q, exp_q);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
